// File: rtl/mem_map_pkg.sv
// mem_map_pkg: CPU address map, open-bus value, region decode and ROM images.
// Shared by memory (top) for decode and read-data selection.
package mem_map_pkg;

    localparam logic [15:0] BOOT_LIMIT = 16'h00FF;
    localparam logic [15:0] ROM_LIMIT  = 16'h7FFF;
    localparam logic [15:0] VRAM_BASE  = 16'h8000;
    localparam logic [15:0] VRAM_LIMIT = 16'h9FFF;
    localparam logic [15:0] CRAM_BASE  = 16'hA000;
    localparam logic [15:0] CRAM_LIMIT = 16'hBFFF;
    localparam logic [15:0] WRAM_BASE  = 16'hC000;
    localparam logic [15:0] WRAM_LIMIT = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE  = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT = 16'hFDFF;
    localparam logic [15:0] OAM_BASE   = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT  = 16'hFE9F;
    localparam logic [15:0] HRAM_BASE  = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT = 16'hFFFE;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    localparam int VRAM_DEPTH  = 8192;
    localparam int RAM8K_DEPTH = 8192;
    localparam int OAM_DEPTH   = 160;
    localparam int HRAM_DEPTH  = 127;

    typedef enum logic [2:0] {
        R_ROM, R_BOOT, R_VRAM, R_CRAM, R_WRAM, R_OAM, R_HRAM, R_NONE
    } region_t;

    typedef enum logic [1:0] {P_NONE, P_VRAM, P_OAM} ppu_sel_t;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return a >= lo && a <= hi;
    endfunction

    // Echo space folds onto work RAM; the low 13 address bits already index it.
    function automatic region_t decode(input logic [15:0] a, input logic boot);
        return (boot && a <= BOOT_LIMIT)             ? R_BOOT :
               (a <= ROM_LIMIT)                      ? R_ROM  :
               in_range(a, VRAM_BASE, VRAM_LIMIT)    ? R_VRAM :
               in_range(a, CRAM_BASE, CRAM_LIMIT)    ? R_CRAM :
               (in_range(a, WRAM_BASE, WRAM_LIMIT) ||
                in_range(a, ECHO_BASE, ECHO_LIMIT))  ? R_WRAM :
               in_range(a, OAM_BASE, OAM_LIMIT)      ? R_OAM  :
               in_range(a, HRAM_BASE, HRAM_LIMIT)    ? R_HRAM : R_NONE;
    endfunction

    // ROM images; bytes not listed read as 0x00.
    function automatic logic [7:0] boot_rom_byte(input logic [7:0] a);
        return a == 8'd0 ? 8'h31 : a == 8'd1 ? 8'hFE : a == 8'd2 ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] cart_rom_byte(input logic [14:0] a);
        return a == 15'd0 ? 8'hC3 : a == 15'd1 ? 8'hE8 : a == 15'd2 ? 8'h01 : 8'h00;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// dp_ram: byte RAM with a synchronous CPU read/write port and a synchronous PPU read port.
// Ports: clock; a_* CPU port (read returns pre-write data); b_* PPU read port.
module dp_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (a_we) mem[a_addr] <= a_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/memory.sv
// memory: CPU/PPU memory system with boot ROM overlay, RAM regions and PPU bus blocking.
// Ports: clock, reset_n (async low); boot_rom_en; cpu_addr/cpu_wren/cpu_data_in -> cpu_data_out
// (1-cycle registered); ppu_addr/ppu_vram_read_en/ppu_oam_read_en -> ppu_data_out (1-cycle);
// ppu_data_in reserved. Both outputs read 0xFF while reset_n is low.
module memory
    import mem_map_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        boot_rom_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic [12:0] ppu_addr,
    input  logic        ppu_vram_read_en,
    input  logic        ppu_oam_read_en,
    input  logic [7:0]  ppu_data_in,
    output logic [7:0]  ppu_data_out
);

    region_t  dec_rgn, cpu_rgn, cpu_sel_q;
    ppu_sel_t ppu_sel, ppu_sel_q;
    logic [7:0] rd_q, vram_cpu_q, vram_ppu_q, oam_cpu_q, oam_ppu_q;
    logic [7:0] wram [RAM8K_DEPTH];
    logic [7:0] cram [RAM8K_DEPTH];
    logic [7:0] hram [HRAM_DEPTH];
    logic unused_ppu_data;

    assign unused_ppu_data = ^ppu_data_in;

    // A region owned by the PPU this cycle looks unmapped to the CPU.
    assign dec_rgn = decode(cpu_addr, boot_rom_en);
    assign cpu_rgn = ((dec_rgn == R_VRAM && ppu_vram_read_en) ||
                      (dec_rgn == R_OAM  && ppu_oam_read_en)) ? R_NONE : dec_rgn;

    assign ppu_sel = ppu_vram_read_en ? P_VRAM :
                     (ppu_oam_read_en && ppu_addr[7:0] <= OAM_LIMIT[7:0]) ? P_OAM : P_NONE;

    dp_ram #(.DEPTH(VRAM_DEPTH)) u_vram (
        .clock   (clock),
        .a_addr  (cpu_addr[12:0]),
        .a_we    (cpu_wren && cpu_rgn == R_VRAM),
        .a_wdata (cpu_data_in),
        .a_rdata (vram_cpu_q),
        .b_addr  (ppu_addr[12:0]),
        .b_rdata (vram_ppu_q)
    );

    dp_ram #(.DEPTH(OAM_DEPTH)) u_oam (
        .clock   (clock),
        .a_addr  (cpu_addr[7:0]),
        .a_we    (cpu_wren && cpu_rgn == R_OAM),
        .a_wdata (cpu_data_in),
        .a_rdata (oam_cpu_q),
        .b_addr  (ppu_addr[7:0]),
        .b_rdata (oam_ppu_q)
    );

    always_ff @(posedge clock) begin
        if (cpu_wren && cpu_rgn == R_WRAM) wram[cpu_addr[12:0]] <= cpu_data_in;
        if (cpu_wren && cpu_rgn == R_CRAM) cram[cpu_addr[12:0]] <= cpu_data_in;
        if (cpu_wren && cpu_rgn == R_HRAM) hram[cpu_addr[6:0]]  <= cpu_data_in;
    end

    // Selects reset to "none" so both outputs fall to open bus asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_sel_q <= R_NONE;
            ppu_sel_q <= P_NONE;
            rd_q      <= OPEN_BUS;
        end else begin
            cpu_sel_q <= cpu_rgn;
            ppu_sel_q <= ppu_sel;
            rd_q      <= cpu_rgn == R_BOOT ? boot_rom_byte(cpu_addr[7:0])  :
                         cpu_rgn == R_ROM  ? cart_rom_byte(cpu_addr[14:0]) :
                         cpu_rgn == R_CRAM ? cram[cpu_addr[12:0]]          :
                         cpu_rgn == R_WRAM ? wram[cpu_addr[12:0]]          :
                         cpu_rgn == R_HRAM ? hram[cpu_addr[6:0]]           : OPEN_BUS;
        end
    end

    assign cpu_data_out = cpu_sel_q == R_VRAM ? vram_cpu_q :
                          cpu_sel_q == R_OAM  ? oam_cpu_q  : rd_q;
    assign ppu_data_out = ppu_sel_q == P_VRAM ? vram_ppu_q :
                          ppu_sel_q == P_OAM  ? oam_ppu_q  : OPEN_BUS;

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed and randomized checks of memory against a flat 64 KiB reference model.
module tb_memory;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        boot_rom_en = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_wren = 1'b0;
    logic [7:0]  cpu_data_in = '0;
    logic [7:0]  cpu_data_out;
    logic [12:0] ppu_addr = '0;
    logic        ppu_vram_read_en = 1'b0;
    logic        ppu_oam_read_en = 1'b0;
    logic [7:0]  ppu_data_in = '0;
    logic [7:0]  ppu_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m   [65536];
    bit         known_m [65536];
    logic [7:0] ec, ep;
    bit         kc, kp;

    memory dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .boot_rom_en      (boot_rom_en),
        .cpu_addr         (cpu_addr),
        .cpu_wren         (cpu_wren),
        .cpu_data_in      (cpu_data_in),
        .cpu_data_out     (cpu_data_out),
        .ppu_addr         (ppu_addr),
        .ppu_vram_read_en (ppu_vram_read_en),
        .ppu_oam_read_en  (ppu_oam_read_en),
        .ppu_data_in      (ppu_data_in),
        .ppu_data_out     (ppu_data_out)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] canon(input logic [15:0] a);
        return (a >= 16'hE000 && a <= 16'hFDFF) ? a - 16'h2000 : a;
    endfunction

    function automatic bit is_ram(input logic [15:0] a, input logic vb, input logic ob);
        return (a >= 16'h8000 && a <= 16'h9FFF && !vb) || (a >= 16'hA000 && a <= 16'hFDFF) ||
               (a >= 16'hFE00 && a <= 16'hFE9F && !ob) || (a >= 16'hFF80 && a <= 16'hFFFE);
    endfunction

    // Computes expected outputs from the model's pre-edge state, drives one cycle,
    // then commits the write into the model.
    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d,
                        input logic boot, input logic vb, input logic ob, input logic [12:0] pa);
        kc = 1'b1; kp = 1'b1; ec = 8'hFF; ep = 8'hFF;
        if (boot && a <= 16'h00FF) begin
            kc = a < 16'd3;
            ec = a == 16'd0 ? 8'h31 : a == 16'd1 ? 8'hFE : 8'hFF;
        end else if (a <= 16'h7FFF) begin
            kc = a < 16'd3;
            ec = a == 16'd0 ? 8'hC3 : a == 16'd1 ? 8'hE8 : 8'h01;
        end else if (is_ram(a, vb, ob)) begin
            kc = known_m[canon(a)];
            ec = mem_m[canon(a)];
        end
        if (vb) begin
            kp = known_m[16'h8000 + {3'b000, pa}];
            ep = mem_m[16'h8000 + {3'b000, pa}];
        end else if (ob && pa[7:0] < 8'hA0) begin
            kp = known_m[{8'hFE, pa[7:0]}];
            ep = mem_m[{8'hFE, pa[7:0]}];
        end
        cpu_addr = a; cpu_wren = we; cpu_data_in = d; boot_rom_en = boot;
        ppu_vram_read_en = vb; ppu_oam_read_en = ob; ppu_addr = pa;
        @(posedge clock);
        #1;
        cpu_wren = 1'b0;
        if (we && is_ram(a, vb, ob)) begin
            mem_m[canon(a)] = d;
            known_m[canon(a)] = 1'b1;
        end
    endtask

    task automatic test_reset();
        ppu_vram_read_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (cpu_data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_cpu got=%h exp=ff", cpu_data_out); end
        n_tests++;
        if (ppu_data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_ppu got=%h exp=ff", ppu_data_out); end
        reset_n = 1'b1;
        step(16'h0000, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'hC3) begin n_fail++; $display("FAIL first_read got=%h exp=c3", cpu_data_out); end
    endtask

    task automatic test_boot_rom();
        logic [7:0] exp [6] = '{8'h31, 8'hFE, 8'hFF, 8'hC3, 8'hE8, 8'h01};
        for (int i = 0; i < 6; i++) begin
            step(16'(i % 3), 0, 0, i < 3, 0, 0, 0);
            n_tests++;
            if (cpu_data_out !== exp[i]) begin
                n_fail++; $display("FAIL boot_rom[%0d] got=%h exp=%h", i, cpu_data_out, exp[i]);
            end
        end
    endtask

    // Shared scenario for the two PPU-owned regions: fill, read, PPU read, block.
    task automatic test_ppu_region(input logic [15:0] base, input bit oam);
        step(base, 1, 8'h12, 0, 0, 0, 0);
        step(base + 16'd1, 1, 8'h34, 0, 0, 0, 0);
        step(base, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h12) begin n_fail++; $display("FAIL %h_rd0 got=%h exp=12", base, cpu_data_out); end
        step(base + 16'd1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h34) begin n_fail++; $display("FAIL %h_rd1 got=%h exp=34", base, cpu_data_out); end
        step(16'h0000, 0, 0, 0, !oam, oam, 13'd1);
        n_tests++;
        if (ppu_data_out !== 8'h34) begin n_fail++; $display("FAIL %h_ppu1 got=%h exp=34", base, ppu_data_out); end
        n_tests++;
        if (cpu_data_out !== 8'hC3) begin n_fail++; $display("FAIL %h_rom_unblocked got=%h exp=c3", base, cpu_data_out); end
        step(base + 16'd1, 0, 0, 0, !oam, oam, 13'd1);
        n_tests++;
        if (cpu_data_out !== 8'hFF) begin n_fail++; $display("FAIL %h_blocked_rd got=%h exp=ff", base, cpu_data_out); end
        step(base + 16'd1, 1, 8'h78, 0, !oam, oam, 13'd0);
        step(base + 16'd1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h34) begin n_fail++; $display("FAIL %h_blocked_wr got=%h exp=34", base, cpu_data_out); end
    endtask

    task automatic test_ppu_priority();
        step(16'h8002, 1, 8'h5C, 0, 0, 0, 0);
        step(16'hFE02, 1, 8'h9A, 0, 0, 0, 0);
        step(16'hC000, 0, 0, 0, 1, 1, 13'd2);
        n_tests++;
        if (ppu_data_out !== 8'h5C) begin n_fail++; $display("FAIL ppu_priority got=%h exp=5c", ppu_data_out); end
        step(16'hC000, 0, 0, 0, 0, 1, 13'd2);
        n_tests++;
        if (ppu_data_out !== 8'h9A) begin n_fail++; $display("FAIL ppu_oam got=%h exp=9a", ppu_data_out); end
        step(16'hC000, 0, 0, 0, 0, 1, 13'h0A0);
        n_tests++;
        if (ppu_data_out !== 8'hFF) begin n_fail++; $display("FAIL ppu_oam_a0 got=%h exp=ff", ppu_data_out); end
        step(16'hC000, 0, 0, 0, 0, 0, 13'd2);
        n_tests++;
        if (ppu_data_out !== 8'hFF) begin n_fail++; $display("FAIL ppu_idle got=%h exp=ff", ppu_data_out); end
    endtask

    task automatic test_wram_echo();
        logic [15:0] ra [4] = '{16'hC000, 16'hC001, 16'hE000, 16'hE001};
        logic [7:0]  rv [4] = '{8'h12, 8'h34, 8'h12, 8'h34};
        step(16'hC000, 1, 8'h12, 0, 0, 0, 0);
        step(16'hC001, 1, 8'h34, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(ra[i], 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (cpu_data_out !== rv[i]) begin n_fail++; $display("FAIL wram_%h got=%h exp=%h", ra[i], cpu_data_out, rv[i]); end
        end
        step(16'hFDFF, 1, 8'h56, 0, 0, 0, 0);
        step(16'hDDFF, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h56) begin n_fail++; $display("FAIL echo_wr got=%h exp=56", cpu_data_out); end
    endtask

    task automatic test_unmapped();
        logic [15:0] ua [4] = '{16'hFEA0, 16'hFF00, 16'hFF7F, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            step(ua[i], 1, 8'h00, 0, 0, 0, 0);
            step(ua[i], 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (cpu_data_out !== 8'hFF) begin n_fail++; $display("FAIL unmapped_%h got=%h exp=ff", ua[i], cpu_data_out); end
        end
        step(16'h0001, 1, 8'h99, 0, 0, 0, 0);
        step(16'h0001, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'hE8) begin n_fail++; $display("FAIL rom_wr got=%h exp=e8", cpu_data_out); end
        step(16'hFF80, 1, 8'hA5, 0, 0, 0, 0);
        step(16'hFFFE, 1, 8'h5A, 0, 0, 0, 0);
        step(16'hFF80, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'hA5) begin n_fail++; $display("FAIL hram_lo got=%h exp=a5", cpu_data_out); end
        step(16'hFFFE, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h5A) begin n_fail++; $display("FAIL hram_hi got=%h exp=5a", cpu_data_out); end
    endtask

    task automatic test_read_old();
        step(16'hA010, 1, 8'h55, 0, 0, 0, 0);
        step(16'hA010, 1, 8'h66, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h55) begin n_fail++; $display("FAIL read_old got=%h exp=55", cpu_data_out); end
        step(16'hA010, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (cpu_data_out !== 8'h66) begin n_fail++; $display("FAIL read_new got=%h exp=66", cpu_data_out); end
    endtask

    task automatic test_async_reset();
        step(16'hC000, 0, 0, 0, 1, 0, 13'd1);
        n_tests++;
        if (cpu_data_out !== 8'h12 || ppu_data_out !== 8'h34) begin
            n_fail++; $display("FAIL pre_reset got=%h/%h exp=12/34", cpu_data_out, ppu_data_out);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (cpu_data_out !== 8'hFF || ppu_data_out !== 8'hFF) begin
            n_fail++; $display("FAIL async_reset got=%h/%h exp=ff/ff", cpu_data_out, ppu_data_out);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (cpu_data_out !== 8'hFF || ppu_data_out !== 8'hFF) begin
            n_fail++; $display("FAIL reset_hold got=%h/%h exp=ff/ff", cpu_data_out, ppu_data_out);
        end
        reset_n = 1'b1;
        step(16'hC000, 0, 0, 0, 1, 0, 13'd1);
        n_tests++;
        if (cpu_data_out !== 8'h12 || ppu_data_out !== 8'h34) begin
            n_fail++; $display("FAIL ram_retained got=%h/%h exp=12/34", cpu_data_out, ppu_data_out);
        end
    endtask

    task automatic test_random();
        logic [15:0] bases [10] = '{16'h0000, 16'h8000, 16'h9FFC, 16'hA000, 16'hBFFC,
                                    16'hC000, 16'hE000, 16'hFE9C, 16'hFF7C, 16'hFFF8};
        logic [15:0] a;
        logic [12:0] pa;
        for (int i = 0; i < 800; i++) begin
            a  = bases[$urandom_range(0, 9)] + 16'($urandom_range(0, 7));
            pa = $urandom_range(0, 1) ? 13'($urandom_range(0, 7))
                                      : {5'($urandom_range(0, 31)), 8'h9C + 8'($urandom_range(0, 7))};
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, pa);
            if (kc) begin
                n_tests++;
                if (cpu_data_out !== ec) begin n_fail++; $display("FAIL rand_cpu[%0d] addr=%h got=%h exp=%h", i, a, cpu_data_out, ec); end
            end
            if (kp) begin
                n_tests++;
                if (ppu_data_out !== ep) begin n_fail++; $display("FAIL rand_ppu[%0d] paddr=%h got=%h exp=%h", i, pa, ppu_data_out, ep); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_rom();
        test_ppu_region(16'h8000, 1'b0);
        test_ppu_region(16'hFE00, 1'b1);
        test_ppu_priority();
        test_wram_echo();
        test_unmapped();
        test_read_old();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- boot_rom_en  in  1  1 = boot ROM overlays 0x0000-0x00FF.
- cpu_addr  in  16  CPU byte address.
- cpu_wren  in  1  CPU write strobe, sampled at rising edge.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  CPU read data, registered.
- ppu_addr  in  13  PPU byte offset into VRAM or OAM.
- ppu_vram_read_en  in  1  PPU owns VRAM this cycle.
- ppu_oam_read_en  in  1  PPU owns OAM this cycle.
- ppu_data_in  in  8  reserved; ignored.
- ppu_data_out  out  8  PPU read data, registered.

Function
REQ-002 The CPU address decode SHALL be as follows.
- 0x0000-0x7FFF: cart ROM, 32 KiB, init file.
- 0x8000-0x9FFF: VRAM, 8 KiB.
- 0xA000-0xBFFF: cart RAM, 8 KiB.
- 0xC000-0xDFFF: work RAM, 8 KiB.
- 0xE000-0xFDFF: echo of work RAM at addr-0x2000.
- 0xFE00-0xFE9F: OAM, 160 B.
- 0xFF80-0xFFFE: HRAM, 127 B.
- Anything else: unmapped.
REQ-003 While boot_rom_en=1, CPU reads of 0x0000-0x00FF SHALL return the 256-byte boot ROM (init file; bytes 0..2 = 0x31,0xFE,0xFF); otherwise they SHALL return cart ROM (bytes 0..2 = 0xC3,0xE8,0x01).
REQ-004 CPU read latency SHALL be one cycle: cpu_data_out updates at the rising edge after cpu_addr is presented and holds until the next edge.
REQ-005 A CPU write SHALL commit at the rising edge where cpu_wren=1, to the RAM region decoded from cpu_addr; the echo region SHALL write work RAM.
REQ-006 CPU writes to ROM, boot ROM and unmapped addresses SHALL be ignored.
REQ-007 Reads of unmapped addresses SHALL return 0xFF.
REQ-008 While ppu_vram_read_en=1, the CPU SHALL be blocked from VRAM: reads of 0x8000-0x9FFF return 0xFF and writes there are dropped.
REQ-009 While ppu_oam_read_en=1, the CPU SHALL be blocked from OAM: reads of 0xFE00-0xFE9F return 0xFF and writes there are dropped.
REQ-010 Blocking SHALL NOT affect CPU access to other regions; blocking is evaluated at the same edge as the access.
REQ-011 The PPU read path SHALL have one-cycle latency.
- ppu_vram_read_en=1: ppu_data_out = VRAM[ppu_addr[12:0]].
- else ppu_oam_read_en=1: ppu_data_out = OAM[ppu_addr[7:0]]; index >= 0xA0 returns 0xFF.
- Neither enable: 0xFF.
- VRAM takes priority when both enables are set.
REQ-012 A CPU write and a PPU read of the same location in one cycle cannot occur because of REQ-008/009; a simultaneous CPU read of the same location SHALL return the old data.

Reset
REQ-013 While reset_n=0, cpu_data_out and ppu_data_out SHALL be 0xFF, asynchronously.
REQ-014 Reset SHALL NOT clear RAM contents; ROM contents SHALL come only from the init files.
REQ-015 The first registered read SHALL occur at the first rising edge after reset_n deasserts.

Structure
REQ-016 The region base/limit address constants and the 0xFF open-bus value SHALL reside in a shared package (mem_map_pkg).
REQ-017 VRAM and OAM SHALL each use one sub-module, dp_ram, parameterized by depth, with one synchronous CPU read/write port and one synchronous PPU read port; the other memories SHALL be inferred single-port arrays.

Verification
REQ-018 boot_rom_en=1, read 0x0000/0x0001/0x0002 -> 0x31/0xFE/0xFF; with boot_rom_en=0 -> 0xC3/0xE8/0x01.
REQ-019 Write 0x12 to 0x8000 and 0x34 to 0x8001, read both -> 0x12/0x34; PPU VRAM read at offset 0x0001 -> 0x34.
REQ-020 ppu_vram_read_en=1: CPU read 0x8001 -> 0xFF, read 0x0000 -> 0xC3; write 0x78 to 0x8001; drop the enable; read 0x8001 -> 0x34.
REQ-021 Write 0x12 to 0xC000 and 0x34 to 0xC001; read 0xC000/0xC001 and 0xE000/0xE001 -> 0x12/0x34 each.
REQ-022 Repeat REQ-019/020 for OAM at 0xFE00/0xFE01 with ppu_oam_read_en, and check that reset_n=0 forces both outputs to 0xFF.
